// File: rtl/pc_sequencer.sv
// Control sequencer for an 8-bit program counter: run/halt, stall, relative branch.
// Define PC_SEQ_CALL_EN to compile in the DEPTH-entry call/return stack.
module pc_sequencer #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            startup_n,
  input  logic            start,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            branch_req,
  input  logic [PC_W-1:0] branch_offset,
  input  logic            call_req,
  input  logic            ret_req,
  input  logic [PC_W-1:0] pc,
  output logic            pc_startup,
  output logic [PC_W-1:0] pc_control,
  output logic [PC_W-1:0] jump_offset,
  output logic            busy,
  output logic            done,
  output logic            stack_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [PC_W-1:0] ONES = '1;

  state_t r_state;
  state_t w_next_state;

`ifdef PC_SEQ_CALL_EN
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  r_stack [DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic             r_stack_err;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [PC_W-1:0]  w_top;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;
  logic             w_launch;

  assign w_wr_idx  = IDX_W'(r_sp);
  assign w_rd_idx  = IDX_W'(r_sp - 1'b1);
  assign w_top     = r_stack[w_rd_idx];
  assign w_full    = (r_sp == SP_W'(DEPTH));
  assign w_launch  = (r_state == S_IDLE) && start;
  assign stack_err = r_stack_err;
`else
  logic w_unused;
  assign w_unused  = ret_req ^ (^pc) ^ (DEPTH > 8);
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge startup_n) begin
    if (!startup_n) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  // A hold is pc_control and jump_offset both all-ones: the PC adds 1 - 1.
  always_comb begin
    w_next_state = r_state;
    pc_startup   = 1'b0;
    pc_control   = '0;
    jump_offset  = '0;
    busy         = 1'b0;
    done         = 1'b0;
`ifdef PC_SEQ_CALL_EN
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_err_set    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        pc_startup = 1'b1;
        if (start) w_next_state = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (halt_req) begin
          pc_control   = ONES;
          jump_offset  = ONES;
          w_next_state = S_HALT;
        end else if (stall) begin
          pc_control  = ONES;
          jump_offset = ONES;
`ifdef PC_SEQ_CALL_EN
        end else if (ret_req) begin
          if (r_sp != '0) begin
            w_pop       = 1'b1;
            pc_control  = ONES;
            jump_offset = w_top - pc - 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end else if (call_req) begin
          pc_control  = ONES;
          jump_offset = branch_offset;
          if (w_full) w_err_set = 1'b1;
          else        w_push    = 1'b1;
`else
        end else if (call_req) begin
          pc_control  = ONES;
          jump_offset = branch_offset;
`endif
        end else if (branch_req) begin
          pc_control  = ONES;
          jump_offset = branch_offset;
        end
      end
      S_HALT: begin
        pc_control  = ONES;
        jump_offset = ONES;
        done        = 1'b1;
        if (start) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

`ifdef PC_SEQ_CALL_EN
  // The stack is emptied whenever the sequencer sits in IDLE, so every launch starts clean.
  always_ff @(posedge clk or negedge startup_n) begin
    if (!startup_n) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else if (r_state == S_IDLE) begin
      r_sp <= '0;
    end else if (w_push) begin
      r_stack[w_wr_idx] <= pc + 1'b1;
      r_sp              <= r_sp + 1'b1;
    end else if (w_pop) begin
      r_sp <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge startup_n) begin
    if (!startup_n)     r_stack_err <= 1'b0;
    else if (w_launch)  r_stack_err <= 1'b0;
    else if (w_err_set) r_stack_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural program_counter closes the loop, expected PC
// values are queued with each stimulus cycle and compared one edge later.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       startup_n;
  logic       start;
  logic       halt_req;
  logic       stall;
  logic       branch_req;
  logic [7:0] branch_offset;
  logic       call_req;
  logic       ret_req;
  logic [7:0] pc;
  logic       pc_startup;
  logic [7:0] pc_control;
  logic [7:0] jump_offset;
  logic       busy;
  logic       done;
  logic       stack_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  localparam logic [4:0] R_NONE  = 5'b00000;
  localparam logic [4:0] R_HALT  = 5'b10000;
  localparam logic [4:0] R_STALL = 5'b01000;
  localparam logic [4:0] R_RET   = 5'b00100;
  localparam logic [4:0] R_CALL  = 5'b00010;
  localparam logic [4:0] R_BR    = 5'b00001;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(8), .DEPTH(4)) dut (
    .clk(clk), .startup_n(startup_n), .start(start), .halt_req(halt_req),
    .stall(stall), .branch_req(branch_req), .branch_offset(branch_offset),
    .call_req(call_req), .ret_req(ret_req), .pc(pc), .pc_startup(pc_startup),
    .pc_control(pc_control), .jump_offset(jump_offset), .busy(busy),
    .done(done), .stack_err(stack_err)
  );

  // Behavioural program_counter: loads 0 on startup, else pc + 1 + (control & offset).
  always @(posedge clk) begin
    if (pc_startup) pc <= 8'h00;
    else            pc <= pc + 8'd1 + (pc_control & jump_offset);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; the expected PC after the edge goes into the scoreboard.
  task automatic cyc(input string tag, input logic [4:0] req, input logic [7:0] off,
                     input logic [7:0] exp_pc);
    {halt_req, stall, ret_req, call_req, branch_req} = req;
    branch_offset = off;
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    {halt_req, stall, ret_req, call_req, branch_req} = R_NONE;
    branch_offset = 8'($urandom_range(0, 255));
    if (exp_q.size() == 0) check({tag, "_queue"}, 8'h00, 8'h01);
    else                   check(tag, pc, exp_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_startup"},  8'(pc_startup), 8'd1);
    check({tag, "_pc_control"},  pc_control,     8'h00);
    check({tag, "_jump_offset"}, jump_offset,    8'h00);
    check({tag, "_busy"},        8'(busy),       8'd0);
    check({tag, "_done"},        8'(done),       8'd0);
    check({tag, "_stack_err"},   8'(stack_err),  8'd0);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    startup_n = 1'b0;
    start     = 1'b0;
    {halt_req, stall, ret_req, call_req, branch_req} = R_NONE;
    branch_offset = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_pc", pc, 8'h00);

    // Launch and sequential run
    startup_n = 1'b1;
    start     = 1'b1;
    cyc("launch", R_NONE, 8'h00, 8'h00);
    start = 1'b0;
    check("run_busy", 8'(busy), 8'd1);
    check("run_pc_startup", 8'(pc_startup), 8'd0);
    for (int i = 1; i <= 5; i++) cyc("seq", R_NONE, 8'($urandom_range(0, 255)), 8'(i));

    // Branches, stall, wrap-around
    cyc("br_fwd", R_BR, 8'h03, 8'h09);
    cyc("br_back", R_BR, 8'hFA, 8'h04);
    for (int i = 0; i < 3; i++) cyc("stall", R_STALL | R_BR, 8'($urandom_range(0, 255)), 8'h04);
    cyc("br_to_fe", R_BR, 8'hF9, 8'hFE);
    cyc("seq_ff", R_NONE, 8'h00, 8'hFF);
    cyc("wrap_00", R_NONE, 8'h00, 8'h00);
    check("wrap_stack_err", 8'(stack_err), 8'd0);
    for (int i = 1; i <= 7; i++) cyc("seq2", R_NONE, 8'($urandom_range(0, 255)), 8'(i));

    // Priority: halt beats stall and branch; requests ignored while halted
    cyc("prio_halt", R_HALT | R_STALL | R_BR, 8'h10, 8'h07);
    check("halt_done", 8'(done), 8'd1);
    check("halt_busy", 8'(busy), 8'd0);
    check("halt_pc_control", pc_control, 8'hFF);
    check("halt_jump_offset", jump_offset, 8'hFF);
    cyc("halt_ignore", R_BR | R_CALL, 8'h20, 8'h07);
    start = 1'b1;
    cyc("halt_to_idle", R_NONE, 8'h00, 8'h07);
    check("idle_pc_startup", 8'(pc_startup), 8'd1);
    check("idle_done", 8'(done), 8'd0);
    cyc("relaunch", R_BR, 8'h40, 8'h00);
    start = 1'b0;
    check("relaunch_busy", 8'(busy), 8'd1);
    cyc("seq3_1", R_NONE, 8'h00, 8'h01);
    cyc("seq3_2", R_NONE, 8'h00, 8'h02);

`ifdef PC_SEQ_CALL_EN
    cyc("call", R_CALL, 8'h0A, 8'h0D);
    for (int i = 14; i <= 20; i++) cyc("seq4", R_NONE, 8'($urandom_range(0, 255)), 8'(i));
    cyc("ret", R_RET, 8'($urandom_range(0, 255)), 8'h03);
    check("ret_stack_err", 8'(stack_err), 8'd0);
    for (int i = 4; i <= 6; i++) cyc("seq5", R_NONE, 8'h00, 8'(i));
    cyc("underflow", R_RET, 8'h11, 8'h07);
    check("underflow_err", 8'(stack_err), 8'd1);
    cyc("halt2", R_HALT, 8'h00, 8'h07);
    start = 1'b1;
    cyc("halt2_idle", R_NONE, 8'h00, 8'h07);
    cyc("relaunch2", R_NONE, 8'h00, 8'h00);
    start = 1'b0;
    check("relaunch_err_clr", 8'(stack_err), 8'd0);
    for (int i = 1; i <= 4; i++) cyc("call_fill", R_CALL, 8'h00, 8'(i));
    check("fill_err", 8'(stack_err), 8'd0);
    cyc("overflow", R_CALL, 8'h02, 8'h07);
    check("overflow_err", 8'(stack_err), 8'd1);
    for (int i = 4; i >= 1; i--) cyc("ret_unwind", R_RET, 8'h00, 8'(i));
`else
    cyc("call_as_br", R_CALL, 8'h0A, 8'h0D);
    cyc("ret_ignored", R_RET, 8'($urandom_range(0, 255)), 8'h0E);
    check("nostack_err", 8'(stack_err), 8'd0);
`endif

    // Asynchronous reset between edges while a branch is being driven
    #2;
    branch_req    = 1'b1;
    branch_offset = 8'h33;
    #1;
    check("pre_rst_pc_control", pc_control, 8'hFF);
    startup_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    branch_req = 1'b0;
    exp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    check("async_rst_pc", pc, exp_q.pop_front());
    startup_n = 1'b1;
    start     = 1'b1;
    cyc("post_rst_launch", R_NONE, 8'h00, 8'h00);
    start = 1'b0;
    cyc("post_rst_seq", R_NONE, 8'h00, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
